// File: rtl/fpr_pkg.sv
// Shared types and constants for the floating-point register-file sequencer.
//   FPR_AW / FPR_W : register address width and register width
//   fpr_seq_state_t: sequencer FSM states
//   fpr_req_t      : latched request payload (write flag, double flag, register, data)
// Vector ranges run MSB-first ([0:N-1]) to match the register-file bus convention.
package fpr_pkg;

  localparam int unsigned FPR_AW = 5;
  localparam int unsigned FPR_W  = 32;
  localparam int unsigned FPR_DW = 2 * FPR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } fpr_seq_state_t;

  typedef struct packed {
    logic              wr;
    logic              dbl;
    logic [0:FPR_AW-1] reg_idx;
    logic [0:FPR_DW-1] wdata;
  } fpr_req_t;

  // Odd register number: the last bit of an MSB-first index is the LSB.
  function automatic logic fpr_is_odd(input logic [0:FPR_AW-1] r);
    return r[FPR_AW-1];
  endfunction

  // Second register of an even/odd pair; the caller guarantees r is even.
  function automatic logic [0:FPR_AW-1] fpr_pair_hi(input logic [0:FPR_AW-1] r);
    return FPR_AW'(r + FPR_AW'(1));
  endfunction

endpackage

// File: rtl/fpr_dword_sequencer.sv
// Sequences single- and double-precision accesses to the 32x32 FP register file.
// A double occupies an even/odd register pair and takes two register-file cycles.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_wr, req_dbl       write / double-precision flags
//   req_reg, req_wdata    target register (even for doubles), write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_err, rsp_rdata    odd-pair rejection flag, assembled read data
//   fpr_rs, fpr_rd        register-file read / write addresses
//   fpr_rdst              destination select, tied high
//   fpr_regwr             register-file write enable (forced low during reset)
//   fpr_busw, fpr_busa    register-file write data / combinational read data
module fpr_dword_sequencer
  import fpr_pkg::*;
#(
  parameter int unsigned REG_AW = FPR_AW,
  parameter int unsigned WORD_W = FPR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic                req_dbl,
  input  logic [0:REG_AW-1]   req_reg,
  input  logic [0:2*WORD_W-1] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_err,
  output logic [0:2*WORD_W-1] rsp_rdata,
  output logic [0:REG_AW-1]   fpr_rs,
  output logic [0:REG_AW-1]   fpr_rd,
  output logic                fpr_rdst,
  output logic                fpr_regwr,
  output logic [0:WORD_W-1]   fpr_busw,
  input  logic [0:WORD_W-1]   fpr_busa
);

  fpr_seq_state_t    state_q, state_d;
  fpr_req_t          req_q, req_d, req_in;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [0:FPR_DW-1] rdata_q, rdata_d;
  logic [0:FPR_AW-1] rs_q, rs_d;
  logic [0:FPR_AW-1] rd_q, rd_d;
  logic              regwr_q, regwr_d;
  logic [0:FPR_W-1]  busw_q, busw_d;
  logic [0:FPR_W-1]  busa;

  assign busa = FPR_W'(fpr_busa);

  // Incoming request in package form.
  always_comb begin
    req_in         = '0;
    req_in.wr      = req_wr;
    req_in.dbl     = req_dbl;
    req_in.reg_idx = FPR_AW'(req_reg);
    req_in.wdata   = FPR_DW'(req_wdata);
  end

  // Next state, request latch, read-data capture and next registered outputs.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rs_d    = rs_q;
    rd_d    = rd_q;
    regwr_d = 1'b0;
    busw_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d   = req_in;
          rdata_d = '0;
          if (req_in.dbl && fpr_is_odd(req_in.reg_idx)) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = LO;
          end
        end
      end
      LO: begin
        if (!req_q.wr) rdata_d[0:FPR_W-1] = busa;
        state_d = req_q.dbl ? HI : RESP;
      end
      HI: begin
        if (!req_q.wr) rdata_d[FPR_W:FPR_DW-1] = busa;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
        else           err_d   = err_q;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    unique case (state_d)
      IDLE: ready_d = 1'b1;
      LO: begin
        rs_d    = req_d.reg_idx;
        rd_d    = req_d.reg_idx;
        regwr_d = req_d.wr;
        if (req_d.wr) busw_d = req_d.wdata[0:FPR_W-1];
      end
      HI: begin
        rs_d    = fpr_pair_hi(req_d.reg_idx);
        rd_d    = fpr_pair_hi(req_d.reg_idx);
        regwr_d = req_d.wr;
        if (req_d.wr) busw_d = req_d.wdata[FPR_W:FPR_DW-1];
      end
      RESP: valid_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rs_q    <= '0;
      rd_q    <= '0;
      regwr_q <= 1'b0;
      busw_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rs_q    <= rs_d;
      rd_q    <= rd_d;
      regwr_q <= regwr_d;
      busw_q  <= busw_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = (2*WORD_W)'(rdata_q);
  assign fpr_rs    = REG_AW'(rs_q);
  assign fpr_rd    = REG_AW'(rd_q);
  assign fpr_rdst  = 1'b1;
  assign fpr_busw  = WORD_W'(busw_q);
  // The register file writes on the falling edge; block it whenever reset is high.
  assign fpr_regwr = regwr_q & ~reset;

endmodule

// File: tb/tb_fpr_dword_sequencer.sv
// Self-checking bench for fpr_dword_sequencer with a behavioural register file.
module tb_fpr_dword_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic        req_dbl;
  logic [4:0]  req_reg;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [63:0] rsp_rdata;
  logic [4:0]  fpr_rs;
  logic [4:0]  fpr_rd;
  logic        fpr_rdst;
  logic        fpr_regwr;
  logic [31:0] fpr_busw;
  logic [31:0] fpr_busa;

  fpr_dword_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_dbl   (req_dbl),
    .req_reg   (req_reg),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .fpr_rs    (fpr_rs),
    .fpr_rd    (fpr_rd),
    .fpr_rdst  (fpr_rdst),
    .fpr_regwr (fpr_regwr),
    .fpr_busw  (fpr_busw),
    .fpr_busa  (fpr_busa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: negedge write, combinational read, cleared by reset.
  logic [31:0] rf [32];
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (fpr_regwr) begin
      rf[fpr_rd] <= fpr_busw;
    end
  end
  assign fpr_busa = rf[fpr_rs];

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the scoreboard on every accepted response.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One request with cycle-exact checks of the register-file side and response latency.
  task automatic do_req(input logic wr, input logic dbl, input logic [4:0] r,
                        input logic [63:0] wd, input logic exp_err, input logic [63:0] exp_rd);
    int   waitc;
    exp_t e;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    chk("req_ready_before", 64'(req_ready), 64'd1);
    e.err   = exp_err;
    e.rdata = exp_rd;
    exp_q.push_back(e);
    req_wr    = wr;
    req_dbl   = dbl;
    req_reg   = r;
    req_wdata = wd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    if (exp_err) begin
      chk("err_lat_valid", 64'(rsp_valid), 64'd1);
      chk("err_no_write", 64'(fpr_regwr), 64'd0);
    end else begin
      chk("lo_valid", 64'(rsp_valid), 64'd0);
      chk("lo_ready", 64'(req_ready), 64'd0);
      chk("lo_rs", 64'(fpr_rs), 64'(r));
      chk("lo_rd", 64'(fpr_rd), 64'(r));
      chk("lo_regwr", 64'(fpr_regwr), 64'(wr));
      if (wr) chk("lo_busw", 64'(fpr_busw), 64'(wd[63:32]));
      if (dbl) begin
        tick();
        chk("hi_valid", 64'(rsp_valid), 64'd0);
        chk("hi_rs", 64'(fpr_rs), 64'(5'(r + 5'd1)));
        chk("hi_rd", 64'(fpr_rd), 64'(5'(r + 5'd1)));
        chk("hi_regwr", 64'(fpr_regwr), 64'(wr));
        if (wr) chk("hi_busw", 64'(fpr_busw), 64'(wd[31:0]));
      end
      tick();
      chk("rsp_lat_valid", 64'(rsp_valid), 64'd1);
      chk("resp_regwr", 64'(fpr_regwr), 64'd0);
    end
    tick();
    chk("idle_ready", 64'(req_ready), 64'd1);
    chk("idle_valid", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    exp_t e;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_dbl   = 1'b0;
    req_reg   = 5'd0;
    req_wdata = 64'h0;
    rsp_ready = 1'b1;
    repeat (3) tick();

    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'h0);
    chk("rst_fpr_rs", 64'(fpr_rs), 64'd0);
    chk("rst_fpr_rd", 64'(fpr_rd), 64'd0);
    chk("rst_fpr_regwr", 64'(fpr_regwr), 64'd0);
    chk("rst_fpr_busw", 64'(fpr_busw), 64'd0);
    chk("rst_fpr_rdst", 64'(fpr_rdst), 64'd1);
    reset = 1'b0;
    tick();

    // Double write / read of pair 4:5.
    do_req(1'b1, 1'b1, 5'd4, 64'h3FF00000_00000000, 1'b0, 64'h0);
    do_req(1'b0, 1'b1, 5'd4, 64'h0, 1'b0, 64'h3FF00000_00000000);
    // Pair 6:7 with both halves nonzero.
    do_req(1'b1, 1'b1, 5'd6, 64'hDEADBEEF_12345678, 1'b0, 64'h0);
    do_req(1'b0, 1'b1, 5'd6, 64'h0, 1'b0, 64'hDEADBEEF_12345678);
    // Single write / read of the top register.
    do_req(1'b1, 1'b0, 5'd31, 64'hC0490FDB_00000000, 1'b0, 64'h0);
    do_req(1'b0, 1'b0, 5'd31, 64'h0, 1'b0, 64'hC0490FDB_00000000);
    // Register 0 is ordinary; the low half of single write data is ignored.
    do_req(1'b1, 1'b0, 5'd0, 64'h00000001_FFFFFFFF, 1'b0, 64'h0);
    do_req(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h00000001_00000000);

    // Odd-register double is rejected without touching the register file.
    do_req(1'b1, 1'b0, 5'd7, 64'hA5A5A5A5_00000000, 1'b0, 64'h0);
    do_req(1'b1, 1'b0, 5'd8, 64'h5A5A5A5A_00000000, 1'b0, 64'h0);
    do_req(1'b1, 1'b1, 5'd7, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 64'h0);
    chk("err_rf7_kept", 64'(rf[7]), 64'hA5A5A5A5);
    chk("err_rf8_kept", 64'(rf[8]), 64'h5A5A5A5A);
    do_req(1'b0, 1'b0, 5'd7, 64'h0, 1'b0, 64'hA5A5A5A5_00000000);
    do_req(1'b0, 1'b0, 5'd8, 64'h0, 1'b0, 64'h5A5A5A5A_00000000);
    do_req(1'b0, 1'b1, 5'd3, 64'h0, 1'b1, 64'h0);

    // Backpressure: response held 5 cycles while a second request waits.
    rsp_ready = 1'b0;
    e.err   = 1'b0;
    e.rdata = 64'hC0490FDB_00000000;
    exp_q.push_back(e);
    req_wr    = 1'b0;
    req_dbl   = 1'b0;
    req_reg   = 5'd31;
    req_wdata = 64'h0;
    req_valid = 1'b1;
    tick();
    req_dbl = 1'b1;
    req_reg = 5'd4;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_rdata", rsp_rdata, 64'hC0490FDB_00000000);
      tick();
    end
    e.err   = 1'b0;
    e.rdata = 64'h3FF00000_00000000;
    exp_q.push_back(e);
    rsp_ready = 1'b1;
    tick();
    chk("bp_idle_ready", 64'(req_ready), 64'd1);
    chk("bp_idle_valid", 64'(rsp_valid), 64'd0);
    tick();
    req_valid = 1'b0;
    chk("bp_second_lo_ready", 64'(req_ready), 64'd0);
    chk("bp_second_lo_rs", 64'(fpr_rs), 64'd4);
    tick();
    chk("bp_second_hi_rs", 64'(fpr_rs), 64'd5);
    tick();
    chk("bp_second_valid", 64'(rsp_valid), 64'd1);
    tick();
    chk("bp_done_ready", 64'(req_ready), 64'd1);

    // Reset during the HI cycle of a double write to pair 2:3.
    req_wr    = 1'b1;
    req_dbl   = 1'b1;
    req_reg   = 5'd2;
    req_wdata = 64'h11111111_22222222;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rstmid_lo_regwr", 64'(fpr_regwr), 64'd1);
    tick();
    chk("rstmid_hi_rd", 64'(fpr_rd), 64'd3);
    reset = 1'b1;
    #1;
    chk("rstmid_regwr_gated", 64'(fpr_regwr), 64'd0);
    tick();
    chk("rstmid_req_ready", 64'(req_ready), 64'd1);
    chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstmid_regwr", 64'(fpr_regwr), 64'd0);
    reset = 1'b0;
    tick();
    // Register file was cleared by reset.
    do_req(1'b0, 1'b1, 5'd2, 64'h0, 1'b0, 64'h0);

    repeat (2) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fpr_dword_sequencer.md
Name: fpr_dword_sequencer

Overview:
- Sequences single- and double-precision accesses to the 32x32 floating-point register file, which has one write port and combinational reads.
- A double occupies an even/odd register pair and needs two register-file cycles.
- The block accepts one request at a time via a valid/ready handshake, drives the register-file address, write and data lines, assembles 64-bit read data, and returns a response.
- It sits between the multi-cycle control FSM and the FP register file.

Parameters:
- REG_AW, 5, register address width (32 registers).
- WORD_W, 32, register width; double width is 2*WORD_W.

Ports:
- clk  in  1  clock; posedge-driven; the register file writes on negedge of the same cycle.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_wr  in  1  1 = write, 0 = read.
- req_dbl  in  1  1 = double (register pair), 0 = single.
- req_reg  in  [0:REG_AW-1]  target register; must be even when req_dbl=1.
- req_wdata  in  [0:2*WORD_W-1]  write data; single uses [0:WORD_W-1].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_err  out  1  request rejected (odd register with req_dbl=1).
- rsp_rdata  out  [0:2*WORD_W-1]  read data; single fills [0:WORD_W-1] and zeroes [WORD_W:2*WORD_W-1].
- fpr_rs  out  [0:REG_AW-1]  register-file read address.
- fpr_rd  out  [0:REG_AW-1]  register-file write address.
- fpr_rdst  out  1  constant 1 (destination taken from fpr_rd).
- fpr_regwr  out  1  register-file write enable.
- fpr_busw  out  [0:WORD_W-1]  register-file write data.
- fpr_busa  in  [0:WORD_W-1]  register-file read data (combinational from fpr_rs).

Behaviour:
- States: IDLE, LO, HI, RESP.
- **Reset**
  - State goes to IDLE.
  - req_ready=1 after reset; rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - fpr_rs=0, fpr_rd=0, fpr_regwr=0, fpr_busw=0.
- **IDLE**
  - req_ready=1.
  - On req_valid at a posedge, latch wr, dbl, reg and wdata.
  - If dbl=1 and reg[REG_AW-1]=1: go to RESP with rsp_err=1. No register-file access occurs.
  - Otherwise go to LO.
- **LO**
  - fpr_rs = fpr_rd = reg.
  - Write: fpr_regwr=1, fpr_busw = wdata[0:WORD_W-1].
  - Read: capture fpr_busa into rdata[0:WORD_W-1] at the ending posedge.
  - Next state is HI if dbl, else RESP.
- **HI**
  - fpr_rs = fpr_rd = reg+1 (reg is even, so no wrap).
  - Write: fpr_regwr=1, fpr_busw = wdata[WORD_W:2*WORD_W-1].
  - Read: capture fpr_busa into rdata[WORD_W:2*WORD_W-1].
  - Next state is RESP.
- **RESP**
  - rsp_valid=1; rsp_rdata and rsp_err stay stable.
  - When rsp_ready is high at a posedge, go to IDLE.
  - For writes, rsp_rdata=0.
- **Latency** (acceptance at edge N):
  - Single: LO in cycle N+1, rsp_valid in cycle N+2.
  - Double: LO N+1, HI N+2, rsp_valid N+3.
  - Error: rsp_valid N+1.
  - If rsp_ready is held high, the next request is accepted one cycle after rsp_valid rises.
- **Write enable**
  - fpr_regwr is asserted only in LO/HI of a write.
  - It is gated combinationally by !reset, so no register-file write occurs in any cycle where reset=1.
- **Reset mid-operation**
  - Go to IDLE and drop rsp_valid.
  - A partially written pair is not rolled back; the register file clears itself on reset anyway.
- **Ignored inputs**
  - req_valid is ignored outside IDLE (req_ready=0).
  - rsp_ready is ignored outside RESP.
- **Register 0** is an ordinary FP register with no hardwiring.

Decomposition:
- **Shared package fpr_pkg**
  - State enum fpr_seq_state_t {IDLE, LO, HI, RESP}.
  - FPR_AW=5, FPR_W=32.
  - Request struct (wr, dbl, reg, wdata).
- **No sub-module.** The FSM plus a 64-bit data register is a single module.

Test Plan:
- Reset, then double write: reg=4, wdata=64'h3FF00000_00000000.
  - Required: fpr_regwr high in two consecutive cycles (rd=4 busw=3FF00000, then rd=5 busw=00000000); rsp_valid at N+3 with rsp_err=0.
- Double read: reg=4 after the write above.
  - Required: rsp_rdata=64'h3FF00000_00000000 at N+3; fpr_rs sequence 4 then 5.
- Single write then single read: reg=31, data 32'hC0490FDB.
  - Required: write rsp at N+2; read returns rsp_rdata=64'hC0490FDB_00000000.
- Double request with reg=7.
  - Required: rsp_valid at N+1, rsp_err=1; fpr_regwr never asserted; regs 7 and 8 unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while req_valid=1.
  - Required: req_ready=0 throughout, rsp data stable; second request accepted the cycle after rsp_ready rises.
- Reset asserted during HI of a double write to reg=2.
  - Required: fpr_regwr=0 in that cycle; next cycle state IDLE, req_ready=1, rsp_valid=0.
